// File: rtl/lcd_bus_pkg.sv
// Shared opcodes, state encoding and helpers for the 8080-style LCD bus responder.
package lcd_bus_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 32;

  localparam logic [7:0] DEF_ID1 = 8'h00;
  localparam logic [7:0] DEF_ID2 = 8'h93;
  localparam logic [7:0] DEF_ID3 = 8'h41;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RDDID   = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_RDID
  } bus_state_t;

  // Saturate a 16-bit bus address to the last valid column/row.
  function automatic logic [7:0] clamp_addr(input logic [15:0] value,
                                            input logic [15:0] limit);
    return (value > limit) ? limit[7:0] : value[7:0];
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronisers for the asynchronous bus pins plus registered strobe-edge
// detection, including the illegal wrx/rdx-both-low condition.
module lcd_bus_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       csx,
  input  logic       dcx,
  input  logic       wrx,
  input  logic       rdx,
  input  logic       resx,
  input  logic [7:0] data_in,
  output logic       wr_event,
  output logic       rd_start,
  output logic       rd_end,
  output logic       conflict,
  output logic       csx_sync,
  output logic       resx_sync,
  output logic       dcx_sync,
  output logic [7:0] data_sync
);

  // Packed as {resx, rdx, wrx, dcx, csx}; idle bus has all strobes high.
  localparam logic [4:0] CTL_IDLE = 5'b11101;

  logic [4:0] ctl_meta;
  logic [4:0] ctl_sync;
  logic [7:0] data_meta;
  logic       wrx_sync;
  logic       rdx_sync;
  logic       wrx_prev;
  logic       rdx_prev;
  logic       rel_prev;
  logic       both_prev;
  logic       wr_bad;
  logic       both_low;
  logic       rel_now;

  assign {resx_sync, rdx_sync, wrx_sync, dcx_sync, csx_sync} = ctl_sync;

  assign both_low = ~wrx_sync & ~rdx_sync & ~csx_sync;
  assign rel_now  = rdx_sync | csx_sync;

  // NOTE: every flop here uses <= so all stages sample the previous cycle's values;
  // a blocking assignment would collapse the two-flop chain into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctl_meta  <= CTL_IDLE;
      ctl_sync  <= CTL_IDLE;
      data_meta <= 8'h00;
      data_sync <= 8'h00;
      wrx_prev  <= 1'b1;
      rdx_prev  <= 1'b1;
      rel_prev  <= 1'b1;
      both_prev <= 1'b0;
      wr_bad    <= 1'b0;
      wr_event  <= 1'b0;
      rd_start  <= 1'b0;
      rd_end    <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      ctl_meta  <= {resx, rdx, wrx, dcx, csx};
      ctl_sync  <= ctl_meta;
      data_meta <= data_in;
      data_sync <= data_meta;
      wrx_prev  <= wrx_sync;
      rdx_prev  <= rdx_sync;
      rel_prev  <= rel_now;
      both_prev <= both_low;
      // A wrx low phase that overlapped rdx low must not produce a write on release.
      if (both_low) begin
        wr_bad <= 1'b1;
      end else if (wrx_sync) begin
        wr_bad <= 1'b0;
      end
      wr_event <= wrx_sync & ~wrx_prev & ~csx_sync & ~wr_bad;
      rd_start <= ~rdx_sync & rdx_prev & ~csx_sync & ~both_low;
      rd_end   <= rel_now & ~rel_prev;
      conflict <= both_low & ~both_prev;
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// Emulated panel on an 8080-style LCD bus: decodes the command subset, tracks the
// address window and turns RAMWR bytes into framebuffer write strobes.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int         WIDTH  = DEF_WIDTH,
  parameter int         HEIGHT = DEF_HEIGHT,
  parameter logic [7:0] ID1    = DEF_ID1,
  parameter logic [7:0] ID2    = DEF_ID2,
  parameter logic [7:0] ID3    = DEF_ID3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       csx,
  input  logic       dcx,
  input  logic       wrx,
  input  logic       rdx,
  input  logic       resx,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] fb_x,
  output logic [7:0] fb_y,
  output logic [7:0] fb_data,
  output logic       fb_write,
  output logic       display_on,
  output logic       proto_error
);

  localparam logic [15:0] X_LIMIT = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LIMIT = 16'(HEIGHT - 1);

  logic       wr_event;
  logic       rd_start;
  logic       rd_end;
  logic       conflict;
  logic       csx_sync;
  logic       resx_sync;
  logic       dcx_sync;
  logic [7:0] data_sync;

  bus_state_t state;
  bus_state_t state_next;

  logic [2:0] param_idx;
  logic [7:0] p_start_hi;
  logic [7:0] p_start_lo;
  logic [7:0] p_end_hi;
  logic [7:0] sc, ec, sp, ep;
  logic [7:0] x, y;
  logic [2:0] read_idx;
  logic       rd_active;

  logic        soft_reset;
  logic        err;
  logic        cmd_seen;
  logic        disp_on_set;
  logic        disp_off_set;
  logic        param_store;
  logic        win_commit;
  logic        fb_strobe;
  logic        rd_begin;
  logic        rd_finish;
  logic [15:0] lim;
  logic [7:0]  win_lo;
  logic [7:0]  win_hi;
  logic [7:0]  rd_byte;

  lcd_bus_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .csx       (csx),
    .dcx       (dcx),
    .wrx       (wrx),
    .rdx       (rdx),
    .resx      (resx),
    .data_in   (data_in),
    .wr_event  (wr_event),
    .rd_start  (rd_start),
    .rd_end    (rd_end),
    .conflict  (conflict),
    .csx_sync  (csx_sync),
    .resx_sync (resx_sync),
    .dcx_sync  (dcx_sync),
    .data_sync (data_sync)
  );

  // NOTE: every signal driven here gets a default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    soft_reset   = 1'b0;
    err          = 1'b0;
    cmd_seen     = 1'b0;
    disp_on_set  = 1'b0;
    disp_off_set = 1'b0;
    param_store  = 1'b0;
    win_commit   = 1'b0;
    fb_strobe    = 1'b0;
    rd_begin     = 1'b0;
    rd_finish    = 1'b0;
    lim          = (state == ST_CASET) ? X_LIMIT : Y_LIMIT;
    win_lo       = clamp_addr({p_start_hi, p_start_lo}, lim);
    win_hi       = clamp_addr({p_end_hi, data_sync}, lim);

    if (conflict) begin
      err = 1'b1;
    end else if (wr_event) begin
      if (!dcx_sync) begin
        cmd_seen   = 1'b1;
        state_next = ST_IDLE;
        case (data_sync)
          CMD_NOP:     ;
          CMD_SWRESET: soft_reset   = 1'b1;
          CMD_DISPOFF: disp_off_set = 1'b1;
          CMD_DISPON:  disp_on_set  = 1'b1;
          CMD_CASET:   state_next   = ST_CASET;
          CMD_PASET:   state_next   = ST_PASET;
          CMD_RAMWR:   state_next   = ST_RAMWR;
          CMD_RDDID:   state_next   = ST_RDID;
          default:     err          = 1'b1;
        endcase
      end else begin
        case (state)
          ST_CASET, ST_PASET: begin
            if (param_idx != 3'd4) begin
              param_store = 1'b1;
            end
            if (param_idx == 3'd3) begin
              if (win_lo > win_hi) begin
                err = 1'b1;
              end else begin
                win_commit = 1'b1;
              end
            end
          end
          ST_RAMWR: fb_strobe = 1'b1;
          default:  ;
        endcase
      end
    end else if (state == ST_RDID) begin
      if (rd_start && !rd_active) begin
        rd_begin = 1'b1;
      end else if (rd_end && rd_active) begin
        rd_finish = 1'b1;
      end
    end
  end

  always_comb begin
    case (read_idx)
      3'd1:    rd_byte = ID1;
      3'd2:    rd_byte = ID2;
      3'd3:    rd_byte = ID3;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !resx_sync) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !resx_sync || soft_reset) begin
      param_idx   <= 3'd0;
      p_start_hi  <= 8'h00;
      p_start_lo  <= 8'h00;
      p_end_hi    <= 8'h00;
      sc          <= 8'h00;
      ec          <= X_LIMIT[7:0];
      sp          <= 8'h00;
      ep          <= Y_LIMIT[7:0];
      x           <= 8'h00;
      y           <= 8'h00;
      read_idx    <= 3'd0;
      rd_active   <= 1'b0;
      data_out    <= 8'h00;
      display_on  <= 1'b0;
      fb_write    <= 1'b0;
      fb_x        <= 8'h00;
      fb_y        <= 8'h00;
      fb_data     <= 8'h00;
      proto_error <= 1'b0;
    end else begin
      fb_write    <= fb_strobe;
      proto_error <= err;

      if (disp_on_set) begin
        display_on <= 1'b1;
      end
      if (disp_off_set) begin
        display_on <= 1'b0;
      end

      if (cmd_seen) begin
        param_idx <= 3'd0;
        rd_active <= 1'b0;
        data_out  <= 8'h00;
        if (state_next == ST_RAMWR) begin
          x <= sc;
          y <= sp;
        end
        if (state_next == ST_RDID) begin
          read_idx <= 3'd0;
        end
      end

      if (param_store) begin
        param_idx <= param_idx + 3'd1;
        case (param_idx)
          3'd0:    p_start_hi <= data_sync;
          3'd1:    p_start_lo <= data_sync;
          3'd2:    p_end_hi   <= data_sync;
          default: ;
        endcase
      end

      if (win_commit) begin
        if (state == ST_CASET) begin
          sc <= win_lo;
          ec <= win_hi;
        end else begin
          sp <= win_lo;
          ep <= win_hi;
        end
      end

      if (fb_strobe) begin
        fb_x    <= x;
        fb_y    <= y;
        fb_data <= data_sync;
        if (x < ec) begin
          x <= x + 8'd1;
        end else begin
          x <= sc;
          y <= (y == ep) ? sp : y + 8'd1;
        end
      end

      if (rd_begin) begin
        rd_active <= 1'b1;
        data_out  <= rd_byte;
      end
      if (rd_finish) begin
        rd_active <= 1'b0;
        data_out  <= 8'h00;
        if (read_idx != 3'd4) begin
          read_idx <= read_idx + 3'd1;
        end
      end
    end
  end

  assign data_oe = rd_active & ~csx_sync & (state == ST_RDID);

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Display-side end of the 8080-style parallel LCD bus: csx, dcx, wrx, rdx, resx and an 8-bit data bus.
- Samples the asynchronous bus and decodes a command subset: SWRESET, DISPON/OFF, CASET, PASET, RAMWR and RDDID.
- Turns RAMWR data bytes into windowed framebuffer write strobes.
- Serves as an emulated panel in the FPGA and as the loopback target for the panel-driver bench.

Parameters:
- WIDTH, 128, framebuffer columns; column addresses are clamped to WIDTH-1.
- HEIGHT, 32, framebuffer rows; page addresses are clamped to HEIGHT-1.
- ID1/ID2/ID3, 8'h00/8'h93/8'h41, RDDID response bytes.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- csx  in  1  bus chip select, active low, asynchronous.
- dcx  in  1  0 = command byte, 1 = data byte.
- wrx  in  1  write strobe; the byte is taken on the rising edge.
- rdx  in  1  read strobe, active low.
- resx  in  1  panel hardware reset, active low.
- data_in  in  8  bus data from the initiator.
- data_out  out  8  read data.
- data_oe  out  1  bus output enable.
- fb_x  out  8  pixel column.
- fb_y  out  8  pixel row.
- fb_data  out  8  pixel byte.
- fb_write  out  1  one-cycle framebuffer write strobe.
- display_on  out  1  DISPON state.
- proto_error  out  1  one-cycle error pulse.

Behaviour:
- Reset (reset=1, or synchronised resx=0): all outputs are 0.
  - Window is SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1.
  - State is IDLE; the parameter index and the read index are 0.
  - SWRESET has the same effect as resx=0, except that synchronisers are not cleared.
- Synchronisation: csx, dcx, wrx, rdx, resx and data_in each pass through 2 flops.
- Write event: synchronised wrx goes 0->1 while synchronised csx=0.
  - The event is registered 1 cycle later.
  - fb_write rises on the 4th clock edge after the wrx pin edge.
  - The initiator holds data/dcx for at least 3 clocks after wrx rises.
- Read event: synchronised rdx goes 1->0 while synchronised csx=0.
  - Synchronised rdx/csx returning high ends the read.
- Any command byte (dcx=0) aborts the current state and decodes the new command:
  - 0x00 NOP: go to IDLE.
  - 0x01 SWRESET: reset as above.
  - 0x28: display_on=0.
  - 0x29: display_on=1.
  - 0x2A: enter CASET.
  - 0x2B: enter PASET.
  - 0x2C: enter RAMWR.
  - 0x04: enter RDID.
  - Any other value: IDLE plus a proto_error pulse.
- Data byte in IDLE: discarded.
- CASET/PASET:
  - Bytes 0..3 are start[15:8], start[7:0], end[15:8], end[7:0].
  - The window is committed only on byte 3. Each value is clamped to WIDTH-1 (CASET) or HEIGHT-1 (PASET).
  - If the clamped start exceeds the clamped end, the old window is kept and proto_error pulses.
  - Bytes beyond 4 are ignored.
  - A command arriving before byte 3 leaves the window unchanged.
- RAMWR:
  - On entry, x=SC and y=SP.
  - Each data byte gives fb_write=1 with fb_x=x, fb_y=y, fb_data=byte.
  - Address advance in the next cycle:
    - x<EC: x+1.
    - Otherwise x=SC and y=(y==EP ? SP : y+1).
  - Rows wrap without limit.
- RDID reads:
  - Read index 0..3 returns 0x00 (dummy), ID1, ID2, ID3; later reads return 0x00.
  - data_oe=1 and data_out are valid from the read event until the read ends.
  - The index advances when the read ends.
- data_oe is forced to 0 whenever synchronised csx=1 or state!=RDID.
- Synchronised wrx=0 and rdx=0 together: both are ignored, proto_error pulses, and no state change occurs.
- csx deasserting mid-transaction preserves state, window and indices. Only edges with csx low count.
- Priority within one cycle: reset > resx > protocol error > write event > read event.
- A write event and fb address advance never collide, because events are at least 4 cycles apart due to synchronisation.

Decomposition:
- Package lcd_bus_pkg holds:
  - Command opcode localparams: NOP, SWRESET, DISPOFF, DISPON, CASET, PASET, RAMWR, RDDID.
  - State enum: IDLE, CASET, PASET, RAMWR, RDID.
  - Default ID bytes.
- Sub-module lcd_bus_sync: 2-flop synchroniser plus registered rise/fall detection for the 5 control lines and the data byte.
  - Outputs: wr_event, rd_start, rd_end, resx_sync, dcx_sync, data_sync.

Test Plan:
- Cmd 0x2A, data 00 05 00 07; cmd 0x2B, data 00 02 00 03; cmd 0x2C, data 8 bytes A0..A7 -> fb writes at (5,2)(6,2)(7,2)(5,3)(6,3)(7,3)(5,2)(6,2) with data A0..A7.
- Cmd 0x2A, data 01 00 01 FF (start 256, end 511) -> both clamp to 127, window SC=EC=127. Then 0x2A, data 00 10 00 05 -> proto_error=1 for 1 cycle, window unchanged.
- Cmd 0x04, then 5 rdx low/high pulses -> data_out 00, 00, 93, 41, 00, with data_oe=1 only while rdx is low. csx high during rdx low -> data_oe=0.
- Cmd 0x29 -> display_on=1. resx pulsed low mid-RAMWR -> display_on=0, window full-screen, next data byte produces no fb_write.
- wrx and rdx held low together -> proto_error pulse, no fb_write, state unchanged. Unknown cmd 0x55 followed by data 0x11 -> proto_error, no fb_write.
- Latency check: wrx pin rising edge at cycle N with dcx=1 in RAMWR -> fb_write high exactly at cycle N+4 for one cycle.
